// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word-fall-through byte FIFO feeding the UART transmit handshake
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  drop_sticky
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  drop_q, drop_d;
  logic                  wr_en;
  logic                  rd_en;

  // Flags come only from the registered count; flush blocks both ports for its cycle.
  assign fifo_full   = (count_q == CNT_WIDTH'(DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign fifo_count  = count_q;
  assign in_ready    = !fifo_full && !flush;
  assign out_valid   = !fifo_empty;
  assign out_data    = mem_q[rd_ptr_q];
  assign drop_sticky = drop_q;
  assign wr_en       = in_valid && in_ready;
  assign rd_en       = out_valid && out_ready && !flush;

  // Next-state for pointers, occupancy and the sticky drop flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
      if (in_valid && !in_ready) begin
        drop_d = 1'b1;
      end
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage array; left unreset since the head is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int PACE = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       drop_sticky;

  uart_tx_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .drop_sticky(drop_sticky)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] sb_q[$];
  bit         m_drop = 1'b0;
  logic [7:0] last_pop = 8'h00;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    int         exp_cnt;
    logic       exp_ov;
    logic       exp_drop;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = sb_q.size();
    chk("fifo_count", 32'(fifo_count), 32'(n));
    chk("fifo_empty", 32'(fifo_empty), 32'(n == 0));
    chk("fifo_full", 32'(fifo_full), 32'(n == DEPTH));
    chk("out_valid", 32'(out_valid), 32'(n > 0));
    chk("in_ready", 32'(in_ready), 32'((n < DEPTH) && !flush));
    chk("drop_sticky", 32'(drop_sticky), 32'(m_drop));
    if (n > 0) chk("out_data", 32'(out_data), 32'(sb_q[0]));
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
  endtask

  // One clock: check at the falling edge, update the model at the rising edge.
  task automatic tick();
    int n;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    n = sb_q.size();
    if (!rst_n) begin
      sb_q.delete();
      m_drop = 1'b0;
    end else if (flush) begin
      sb_q.delete();
      m_drop = 1'b0;
    end else begin
      if (in_valid && n == DEPTH) m_drop = 1'b1;
      if (out_ready && n > 0) last_pop = sb_q.pop_front();
      if (in_valid && n < DEPTH) sb_q.push_back(in_data);
    end
    #1;
  endtask

  task automatic drain_all(input int budget);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int c = 0; c < budget && sb_q.size() > 0; c++) tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drain_within_budget", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] hello[12];
    hello = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c, 8'h20, 8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64};

    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h44, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b1, 1'b0};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (10) tick();

    // Table-driven single-cycle behaviour
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      tick();
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_drop", i), 32'(drop_sticky), 32'(vecs[i].exp_drop));
    end
    chk("vec_head", 32'(out_data), 32'h55);
    drain_all(4);

    // "Hello, world" burst, then paced drain
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, hello[i], 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("hello_count", 32'(fifo_count), 32'd12);
    chk("hello_in_ready", 32'(in_ready), 32'd1);
    for (int b = 0; b < 12; b++) begin
      for (int c = 0; c < PACE - 1; c++) tick();
      chk($sformatf("hello_byte%0d", b), 32'(out_data), 32'(hello[b]));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("hello_last", 32'(last_pop), 32'h64);
    chk("hello_empty", 32'(fifo_empty), 32'd1);

    // Fill to full, drop while full, one read frees a slot
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("full_flag", 32'(fifo_full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    chk("full_drop", 32'(drop_sticky), 32'd1);
    chk("full_count_hold", 32'(fifo_count), 32'd16);
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    tick();
    chk("full_after_read", 32'(fifo_count), 32'd15);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    chk("full_refill", 32'(fifo_count), 32'd16);
    drain_all(40);
    chk("full_tail", 32'(last_pop), 32'hAA);

    // Sustained simultaneous write/read with random data
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      tick();
      chk("stream_count", 32'(fifo_count), 32'd8);
    end
    drain_all(20);

    // Flush with both ports active
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_drop", 32'(drop_sticky), 32'd0);
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_first_out", 32'(out_data), 32'h5A);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_first_pop", 32'(last_pop), 32'h5A);

    // Asynchronous reset mid-drain with 7 bytes stored
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    tick();
    chk("pre_rst_count", 32'(fifo_count), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(fifo_count), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    m_drop = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    chk("post_rst_count", 32'(fifo_count), 32'd4);
    drain_all(10);
    chk("post_rst_last", 32'(last_pop), 32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
